// File: rtl/hmcad1520_pkg.sv
`default_nettype none
// hmcad1520_pkg: shared types and constants for the HMCAD1520 LVDS receive path.
// Revision: 1.0
package hmcad1520_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4
    } align_state_t;

    localparam logic [7:0] HMCAD_FRAME_PATTERN = 8'hF0;
    localparam int         HMCAD_DESER_FACTOR  = 8;
    localparam logic [7:0] HMCAD_RELOCK_MAX    = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/hmcad1520_align_ctrl.sv
`default_nettype none
// hmcad1520_align_ctrl: bitslips the frame/data deserializers until the frame word locks.
// Revision: 1.0
module hmcad1520_align_ctrl
    import hmcad1520_pkg::*;
#(
    parameter logic [7:0] FRAME_PATTERN = HMCAD_FRAME_PATTERN,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SLIP_SETTLE   = 4,
    parameter int         MAX_SLIPS     = HMCAD_DESER_FACTOR,
    parameter int         LOSS_COUNT    = 4
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic [7:0] FRAME_VECTOR,
    output logic       BITSLIP,
    output logic       LOCKED,
    output logic       ALIGN_ERR,
    output logic [2:0] SLIP_COUNT,
    output logic [7:0] RELOCK_CNT
);

    // Limits widened by one bit so the incremented counters never wrap before the compare.
    localparam logic [8:0] MATCH_LIM  = 9'(MATCH_COUNT);
    localparam logic [4:0] SETTLE_LIM = 5'(SLIP_SETTLE);
    localparam logic [4:0] LOSS_LIM   = 5'(LOSS_COUNT);
    localparam logic [2:0] SLIP_LAST  = 3'(MAX_SLIPS - 1);

    align_state_t state;
    logic [7:0]   match_cnt;
    logic [3:0]   miss_cnt;
    logic [3:0]   settle_cnt;

    logic         word_ok;
    logic [8:0]   match_next;
    logic [4:0]   miss_next;
    logic [4:0]   settle_next;

    assign word_ok     = (FRAME_VECTOR == FRAME_PATTERN);
    assign match_next  = {1'b0, match_cnt} + 9'd1;
    assign miss_next   = {1'b0, miss_cnt} + 5'd1;
    assign settle_next = {1'b0, settle_cnt} + 5'd1;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            match_cnt  <= 8'd0;
            miss_cnt   <= 4'd0;
            settle_cnt <= 4'd0;
            BITSLIP    <= 1'b0;
            LOCKED     <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            SLIP_COUNT <= 3'd0;
            RELOCK_CNT <= 8'd0;
        end else begin
            BITSLIP <= 1'b0;
            if (!ENABLE) begin
                state      <= ST_IDLE;
                match_cnt  <= 8'd0;
                miss_cnt   <= 4'd0;
                settle_cnt <= 4'd0;
                LOCKED     <= 1'b0;
                ALIGN_ERR  <= 1'b0;
                SLIP_COUNT <= 3'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        match_cnt  <= 8'd0;
                        miss_cnt   <= 4'd0;
                        settle_cnt <= 4'd0;
                        LOCKED     <= 1'b0;
                        ALIGN_ERR  <= 1'b0;
                        SLIP_COUNT <= 3'd0;
                        state      <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (word_ok) begin
                            if (match_next >= MATCH_LIM) begin
                                match_cnt <= 8'd0;
                                miss_cnt  <= 4'd0;
                                LOCKED    <= 1'b1;
                                ALIGN_ERR <= 1'b0;
                                state     <= ST_LOCKED;
                            end else begin
                                match_cnt <= match_next[7:0];
                            end
                        end else begin
                            // The pulse and the slip count update together so both are visible in SLIP.
                            match_cnt <= 8'd0;
                            BITSLIP   <= 1'b1;
                            if (SLIP_COUNT >= SLIP_LAST) begin
                                SLIP_COUNT <= 3'd0;
                                ALIGN_ERR  <= 1'b1;
                            end else begin
                                SLIP_COUNT <= SLIP_COUNT + 3'd1;
                            end
                            state <= ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        settle_cnt <= 4'd0;
                        state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_next >= SETTLE_LIM) begin
                            settle_cnt <= 4'd0;
                            match_cnt  <= 8'd0;
                            state      <= ST_CHECK;
                        end else begin
                            settle_cnt <= settle_next[3:0];
                        end
                    end
                    ST_LOCKED: begin
                        if (word_ok) begin
                            miss_cnt <= 4'd0;
                        end else if (miss_next >= LOSS_LIM) begin
                            // Loss of lock re-enters CHECK directly; a slip only follows a fresh mismatch.
                            miss_cnt   <= 4'd0;
                            match_cnt  <= 8'd0;
                            LOCKED     <= 1'b0;
                            SLIP_COUNT <= 3'd0;
                            if (RELOCK_CNT != HMCAD_RELOCK_MAX) begin
                                RELOCK_CNT <= RELOCK_CNT + 8'd1;
                            end
                            state <= ST_CHECK;
                        end else begin
                            miss_cnt <= miss_next[3:0];
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hmcad1520_align_ctrl.sv
`default_nettype none
// tb_hmcad1520_align_ctrl: randomized event scoreboard for the frame-alignment controller.
// Revision: 1.0
`timescale 1ns/1ps
module tb_hmcad1520_align_ctrl;

    localparam int         M    = 16;
    localparam int         S    = 4;
    localparam int         NSL  = 8;
    localparam int         LOSS = 4;
    localparam logic [7:0] PAT  = 8'hF0;

    logic       CLOCK   = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ENABLE  = 1'b0;
    logic [7:0] FRAME_VECTOR;
    logic       BITSLIP;
    logic       LOCKED;
    logic       ALIGN_ERR;
    logic [2:0] SLIP_COUNT;
    logic [7:0] RELOCK_CNT;

    always #5 CLOCK = ~CLOCK;

    hmcad1520_align_ctrl #(
        .FRAME_PATTERN (PAT),
        .MATCH_COUNT   (M),
        .SLIP_SETTLE   (S),
        .MAX_SLIPS     (NSL),
        .LOSS_COUNT    (LOSS)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .ENABLE       (ENABLE),
        .FRAME_VECTOR (FRAME_VECTOR),
        .BITSLIP      (BITSLIP),
        .LOCKED       (LOCKED),
        .ALIGN_ERR    (ALIGN_ERR),
        .SLIP_COUNT   (SLIP_COUNT),
        .RELOCK_CNT   (RELOCK_CNT)
    );

    typedef struct packed {
        int unsigned cyc;
        logic        bs;
        logic        lk;
        logic        err;
        logic [2:0]  sc;
        logic [7:0]  rc;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          exp_relock = 0;
    logic [7:0]  stim_word = PAT;
    logic        rot_mode = 1'b0;
    int          rot_init = 0;
    int          rot = 0;
    logic        prev_lk = 1'b0;

    function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} >> n;
        return d[7:0];
    endfunction

    assign FRAME_VECTOR = rot_mode ? rotr(PAT, rot) : stim_word;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Channel model: each observed bitslip moves the rotated word one bit closer to alignment.
    always @(negedge CLOCK) begin
        if (!rot_mode)
            rot <= rot_init;
        else if (BITSLIP && rot != 0)
            rot <= rot - 1;
    end

    // Monitor: every bitslip pulse and every LOCKED transition is an event to score.
    always @(negedge CLOCK) begin
        ev_t got;
        ev_t e;
        if (!RESET_N) begin
            prev_lk = 1'b0;
        end else begin
            if (BITSLIP || (LOCKED !== prev_lk)) begin
                got = '{cyc, BITSLIP, LOCKED, ALIGN_ERR, SLIP_COUNT, RELOCK_CNT};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: cyc=%0d bs=%b lk=%b err=%b sc=%0d rc=%0d, none required",
                             got.cyc, got.bs, got.lk, got.err, got.sc, got.rc);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        n_bad++;
                        $display("FAIL event: got cyc=%0d bs=%b lk=%b err=%b sc=%0d rc=%0d, required cyc=%0d bs=%b lk=%b err=%b sc=%0d rc=%0d",
                                 got.cyc, got.bs, got.lk, got.err, got.sc, got.rc,
                                 e.cyc, e.bs, e.lk, e.err, e.sc, e.rc);
                    end
                end
            end
            prev_lk = LOCKED;
        end
    end

    task automatic push(input int unsigned c, input logic bs, input logic lk, input logic err,
                        input logic [2:0] sc, input logic [7:0] rc);
        exp_q.push_back('{c, bs, lk, err, sc, rc});
    endtask

    task automatic check(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge CLOCK);
    endtask

    function automatic logic [7:0] bad_word();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == PAT) b = 8'h00;
        return b;
    endfunction

    task automatic disable_locked();
        push(cyc + 1, 1'b0, 1'b0, 1'b0, 3'd0, 8'(exp_relock));
        ENABLE = 1'b0;
        repeat (3) tick();
    endtask

    task automatic enable_aligned();
        int unsigned k;
        stim_word = PAT;
        k = cyc;
        push(k + 1 + M, 1'b0, 1'b1, 1'b0, 3'd0, 8'(exp_relock));
        ENABLE = 1'b1;
        wait_cyc(k + 1 + M);
        tick();
    endtask

    task automatic rotated(input int r);
        int unsigned k;
        int unsigned lock_c;
        rot_init = r;
        tick();
        rot_mode = 1'b1;
        tick();
        k = cyc;
        for (int n = 1; n <= r; n++)
            push(k + 2 + (n - 1) * (S + 2), 1'b1, 1'b0, 1'b0, 3'(n), 8'(exp_relock));
        lock_c = k + 2 + (r - 1) * (S + 2) + S + 1 + M;
        push(lock_c, 1'b0, 1'b1, 1'b0, 3'(r), 8'(exp_relock));
        ENABLE = 1'b1;
        wait_cyc(lock_c);
        tick();
        disable_locked();
        rot_mode = 1'b0;
        tick();
    endtask

    task automatic zeros(input int nz);
        int unsigned k;
        int unsigned last_p;
        int unsigned lock_c;
        stim_word = 8'h00;
        k = cyc;
        for (int n = 1; n <= nz; n++)
            push(k + 2 + (n - 1) * (S + 2), 1'b1, 1'b0, (n >= NSL), 3'(n % NSL), 8'(exp_relock));
        last_p = k + 2 + (nz - 1) * (S + 2);
        lock_c = last_p + S + 1 + M;
        push(lock_c, 1'b0, 1'b1, 1'b0, 3'(nz % NSL), 8'(exp_relock));
        ENABLE = 1'b1;
        wait_cyc(last_p);
        stim_word = PAT;
        wait_cyc(lock_c);
        tick();
    endtask

    task automatic loss(input int m);
        int unsigned t;
        if (m > 0) begin
            for (int i = 0; i < m; i++) begin
                stim_word = bad_word();
                tick();
            end
            stim_word = PAT;
            tick();
            check("locked_after_partial_miss", int'(LOCKED), 1);
        end
        t = cyc;
        exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
        push(t + LOSS, 1'b0, 1'b0, 1'b0, 3'd0, 8'(exp_relock));
        push(t + LOSS + M, 1'b0, 1'b1, 1'b0, 3'd0, 8'(exp_relock));
        for (int i = 0; i < LOSS; i++) begin
            stim_word = bad_word();
            tick();
        end
        stim_word = PAT;
        wait_cyc(t + LOSS + M);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bitslip"}, int'(BITSLIP), 0);
        check({tag, "_locked"}, int'(LOCKED), 0);
        check({tag, "_align_err"}, int'(ALIGN_ERR), 0);
        check({tag, "_slip_count"}, int'(SLIP_COUNT), 0);
        check({tag, "_relock_cnt"}, int'(RELOCK_CNT), 0);
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    initial begin
        int unsigned k;
        repeat (3) tick();
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        tick();

        enable_aligned();
        check("aligned_slip_count", int'(SLIP_COUNT), 0);
        disable_locked();

        rotated(3);
        for (int i = 0; i < 2; i++) rotated($urandom_range(1, 7));

        zeros($urandom_range(8, 12));

        loss(3);
        disable_locked();
        check("relock_after_disable", int'(RELOCK_CNT), 1);
        enable_aligned();

        for (int i = 0; i < 300; i++) loss($urandom_range(0, LOSS - 1));
        check("relock_saturated", int'(RELOCK_CNT), 255);
        disable_locked();

        // Reset arrives mid-way through a bitslip pulse.
        stim_word = 8'h00;
        k = cyc;
        push(k + 2, 1'b1, 1'b0, 1'b0, 3'd1, 8'(exp_relock));
        ENABLE = 1'b1;
        wait_cyc(k + 2);
        #1 RESET_N = 1'b0;
        exp_relock = 0;
        #1 check_reset_outputs("async_reset");
        ENABLE = 1'b0;
        repeat (2) tick();
        check_reset_outputs("held_reset");
        RESET_N = 1'b1;
        repeat (2) tick();

        check("pending_events", exp_q.size(), 0);
        finish_run();
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: run did not complete, %0d events still pending", exp_q.size());
        finish_run();
    end

endmodule
`default_nettype wire
